// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit.
// Pure combinational functions; no latency, no backpressure.
// Little-endian: byte lane = addr[1:0], half lane = addr[1].
package lsu_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WR     = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [2:0]  funct3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            SZ_B:    r = {{24{b[7]}}, b};
            SZ_H:    r = {{16{h[15]}}, h};
            SZ_BU:   r = {24'd0, b};
            SZ_HU:   r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] data,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  funct3);
        logic [31:0] r;
        r = word;
        if (funct3 == SZ_B) begin
            r[{lane, 3'b000} +: 8] = data[7:0];
        end else if (funct3 == SZ_H) begin
            if (lane[1]) r[31:16] = data[15:0];
            else         r[15:0]  = data[15:0];
        end else begin
            r = data;
        end
        return r;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory bus of the load/store unit.
// slave = the LSU itself; master = pipeline plus memory side.
// Backpressure is req_ready; memory side never stalls.
interface load_store_unit_if #(
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_load;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_fault;
    logic          MemRead;
    logic          MemWrite;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  req_valid, req_load, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output MemRead, MemWrite, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_load, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  MemRead, MemWrite, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Fault check of an incoming request, load extraction and store merge.
// Purely combinational, zero latency, no backpressure.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 32
) (
    input  logic [AW-1:0] chk_addr,
    input  logic [2:0]    chk_funct3,
    input  logic          chk_load,
    output logic          fault,
    input  logic [1:0]    lane,
    input  logic [2:0]    funct3,
    input  logic [31:0]   ext_word,
    output logic [31:0]   ext_data,
    input  logic [31:0]   mrg_word,
    input  logic [31:0]   mrg_data,
    output logic [31:0]   mrg_out
);
    logic illegal;
    logic misalign;
    logic out_of_range;

    // Unsigned store sizes have no meaning, so BU/HU are legal only for loads.
    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        case (chk_funct3)
            3'b000:  ;
            3'b001:  misalign = chk_addr[0];
            3'b010:  misalign = |chk_addr[1:0];
            3'b100:  illegal  = !chk_load;
            3'b101:  begin
                illegal  = !chk_load;
                misalign = chk_addr[0];
            end
            default: illegal = 1'b1;
        endcase
    end

    assign out_of_range = (chk_addr >> 2) >= AW'(DEPTH);
    assign fault        = illegal | misalign | out_of_range;

    assign ext_data = load_extract(ext_word, lane, funct3);
    assign mrg_out  = store_merge(mrg_word, mrg_data, lane, funct3);
endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator with sub-word extract and RMW stores.
// Latency accept->resp: load/SW 2, SB/SH 3, fault 1 cycle.
// req_ready only in IDLE; one request in flight at a time.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    load_store_unit_if.slave        bus
);
    state_e        state_q,  state_d;
    logic [AW-1:0] addr_q,   addr_d;
    logic [2:0]    funct3_q, funct3_d;
    logic          load_q,   load_d;
    logic          fault_q,  fault_d;
    logic [31:0]   data_q,   data_d;

    logic          req_fault;
    logic [31:0]   ext_data;
    logic [31:0]   merge_word;

    lsu_align #(.DEPTH(DEPTH), .AW(AW)) u_align (
        .chk_addr   (bus.req_addr),
        .chk_funct3 (bus.req_funct3),
        .chk_load   (bus.req_load),
        .fault      (req_fault),
        .lane       (addr_q[1:0]),
        .funct3     (funct3_q),
        .ext_word   (data_q),
        .ext_data   (ext_data),
        .mrg_word   (bus.mem_rdata),
        .mrg_data   (data_q),
        .mrg_out    (merge_word)
    );

    // data_q holds store data from accept, then the read word or merged word.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        load_d   = load_q;
        fault_d  = fault_q;
        data_d   = data_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr;
                    funct3_d = bus.req_funct3;
                    load_d   = bus.req_load;
                    data_d   = bus.req_wdata;
                    fault_d  = req_fault;
                    if (req_fault)                   state_d = ST_RESP;
                    else if (bus.req_load)           state_d = ST_RD;
                    else if (bus.req_funct3 == SZ_W) state_d = ST_WR;
                    else                             state_d = ST_RMW_RD;
                end
            end
            ST_RD: begin
                data_d  = bus.mem_rdata;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                data_d  = merge_word;
                state_d = ST_WR;
            end
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            load_q   <= 1'b0;
            fault_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            load_q   <= load_d;
            fault_q  <= fault_d;
            data_q   <= data_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_fault = (state_q == ST_RESP) && fault_q;
    assign bus.resp_rdata = ((state_q == ST_RESP) && load_q && !fault_q) ? ext_data : 32'd0;
    assign bus.MemRead    = (state_q == ST_RD) || (state_q == ST_RMW_RD);
    assign bus.MemWrite   = (state_q == ST_WR);
    assign bus.mem_addr   = (bus.MemRead || bus.MemWrite) ? {addr_q[AW-1:2], 2'b00} : '0;
    assign bus.mem_wdata  = (state_q == ST_WR) ? data_q : 32'd0;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory on the bus, byte-level reference model.
// Directed plan cases, back-to-back, reset during WR, then random traffic.
module tb_load_store_unit;
    localparam int DEPTH = 1024;
    localparam int AW    = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    load_store_unit_if #(.AW(AW)) bus ();

    load_store_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [DEPTH];
    logic [7:0]  ref_b [4*DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    assign bus.mem_rdata = mem[bus.mem_addr[11:2]];
    always @(posedge clk) if (bus.MemWrite) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction

    task automatic set_word(input int w, input logic [31:0] v);
        mem[w] = v;
        for (int k = 0; k < 4; k++) ref_b[4*w+k] = 8'(v >> (8*k));
    endtask

    task automatic run_op(input logic ld, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        int nb, exp_lat, cyc, rd_n, wr_n, both, rd_cyc, wr_cyc;
        logic ill, exp_fault, got, fault;
        logic [31:0] exp_rdata, exp_word, rdata, rd_addr, wr_addr, wr_dat;
        logic [63:0] val;
        int base;
        case (f3)
            3'd0, 3'd4: nb = 1;
            3'd1, 3'd5: nb = 2;
            3'd2:       nb = 4;
            default:    nb = 0;
        endcase
        ill       = (nb == 0) || (!ld && f3[2]);
        exp_fault = ill || ((addr % nb) != 0) || ((addr / 4) >= DEPTH);
        exp_lat   = exp_fault ? 1 : ((ld || nb == 4) ? 2 : 3);
        exp_rdata = 32'd0;
        exp_word  = 32'd0;
        base      = int'(addr & ~32'd3);
        if (!exp_fault && ld) begin
            val = 0;
            for (int i = 0; i < nb; i++) val = val + (64'(ref_b[int'(addr)+i]) << (8*i));
            if (!f3[2] && nb < 4 && val[8*nb-1]) val = val - (64'd1 << (8*nb));
            exp_rdata = val[31:0];
        end
        if (!exp_fault && !ld) begin
            for (int i = 0; i < 4; i++) begin
                logic [7:0] bv;
                if (base + i >= int'(addr) && base + i < int'(addr) + nb)
                    bv = 8'(wd >> (8*(base + i - int'(addr))));
                else
                    bv = ref_b[base+i];
                exp_word = exp_word | (32'(bv) << (8*i));
            end
        end

        @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_load = ld; bus.req_funct3 = f3;
        bus.req_addr = addr;  bus.req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        cyc = 1; got = 0; rd_n = 0; wr_n = 0; both = 0; rd_cyc = 0; wr_cyc = 0;
        rdata = 0; fault = 0; rd_addr = 0; wr_addr = 0; wr_dat = 0;
        while (!got && cyc <= 8) begin
            if (bus.MemRead && bus.MemWrite) both++;
            if (bus.MemRead)  begin rd_n++; rd_cyc = cyc; rd_addr = bus.mem_addr; end
            if (bus.MemWrite) begin wr_n++; wr_cyc = cyc; wr_addr = bus.mem_addr; wr_dat = bus.mem_wdata; end
            if (bus.resp_valid) begin
                got = 1; rdata = bus.resp_rdata; fault = bus.resp_fault;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("resp_seen", 32'(got), 32'd1);
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("resp_fault", 32'(fault), 32'(exp_fault));
        chk("resp_rdata", rdata, exp_rdata);
        chk("rd_wr_exclusive", 32'(both), 32'd0);
        if (exp_fault) begin
            chk("fault_no_mem", 32'(rd_n + wr_n), 32'd0);
        end else if (ld) begin
            chk("ld_rd_cycle", 32'(rd_cyc), 32'd1);
            chk("ld_rd_addr", rd_addr, 32'(base));
            chk("ld_no_write", 32'(wr_n), 32'd0);
        end else begin
            chk("st_rd_count", 32'(rd_n), (nb == 4) ? 32'd0 : 32'd1);
            chk("st_wr_cycle", 32'(wr_cyc), 32'(exp_lat - 1));
            chk("st_wr_addr", wr_addr, 32'(base));
            chk("st_wr_data", wr_dat, exp_word);
            for (int k = 0; k < 4; k++) ref_b[base+k] = 8'(exp_word >> (8*k));
        end
    endtask

    initial begin
        int seen;
        bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = '0; bus.req_wdata = '0;
        for (int w = 0; w < DEPTH; w++) set_word(w, (w < 16) ? $urandom : 32'd0);
        set_word(0, 32'h12345678);
        set_word(1, 32'hABCDEF00);

        rst_n = 1'b0;
        #12;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_fault", 32'(bus.resp_fault), 32'd0);
        chk("rst_memread", 32'(bus.MemRead), 32'd0);
        chk("rst_memwrite", 32'(bus.MemWrite), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b1, 3'b010, 32'h4, 32'h0);
        run_op(1'b1, 3'b000, 32'h5, 32'h0);
        run_op(1'b1, 3'b100, 32'h5, 32'h0);
        run_op(1'b1, 3'b001, 32'h6, 32'h0);
        run_op(1'b1, 3'b101, 32'h2, 32'h0);
        run_op(1'b0, 3'b000, 32'h1, 32'h000000AA);
        chk("sb_mem_word0", mem[0], 32'h1234AA78);
        run_op(1'b1, 3'b010, 32'h0, 32'h0);
        run_op(1'b0, 3'b010, 32'h2, 32'hDEADBEEF);
        chk("sw_fault_mem_unchanged", mem[0], 32'h1234AA78);
        run_op(1'b1, 3'b001, 32'h3, 32'h0);
        run_op(1'b1, 3'b010, 32'h1000, 32'h0);
        run_op(1'b1, 3'b011, 32'h0, 32'h0);

        // Back-to-back: req_valid held high over two LWs.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_load = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h4;
        @(posedge clk);
        @(negedge clk);
        bus.req_addr = 32'h0;
        chk("b2b_c1_ready", 32'(bus.req_ready), 32'd0);
        chk("b2b_c1_memread", 32'(bus.MemRead), 32'd1);
        @(negedge clk);
        chk("b2b_c2_ready", 32'(bus.req_ready), 32'd0);
        chk("b2b_c2_resp", 32'(bus.resp_valid), 32'd1);
        chk("b2b_c2_rdata", bus.resp_rdata, ref_word(1));
        @(negedge clk);
        chk("b2b_c3_ready", 32'(bus.req_ready), 32'd1);
        chk("b2b_c3_no_read", 32'(bus.MemRead), 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("b2b_c4_memread", 32'(bus.MemRead), 32'd1);
        chk("b2b_c4_addr", bus.mem_addr, 32'h0);
        @(negedge clk);
        chk("b2b_c5_resp", 32'(bus.resp_valid), 32'd1);
        chk("b2b_c5_rdata", bus.resp_rdata, ref_word(0));

        // Reset asserted while an SH sits in WR.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_load = 1'b0; bus.req_funct3 = 3'b001;
        bus.req_addr = 32'h2; bus.req_wdata = 32'h0000BEEF;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rstwr_c1_memread", 32'(bus.MemRead), 32'd1);
        @(negedge clk);
        chk("rstwr_c2_memwrite", 32'(bus.MemWrite), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstwr_memwrite_drop", 32'(bus.MemWrite), 32'd0);
        chk("rstwr_mem_addr", bus.mem_addr, 32'd0);
        chk("rstwr_mem_wdata", bus.mem_wdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.resp_valid) seen++;
            @(negedge clk);
        end
        chk("rstwr_no_resp", 32'(seen), 32'd0);
        chk("rstwr_ready", 32'(bus.req_ready), 32'd1);
        chk("rstwr_mem_unchanged", mem[0], ref_word(0));

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 255)
                                             : 32'($urandom_range(0, 63));
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        for (int w = 0; w < 16; w++) chk($sformatf("final_mem%0d", w), mem[w], ref_word(w));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
